// File: rtl/cpa_pipe_nbits_if.sv
// Operand/result handshake bundle for the pipelined carry-propagate adder.
// The adder drives the slave side; the producer/consumer side uses master.
interface cpa_pipe_nbits_if #(
  parameter int BITS = 40
);
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] a;
  logic [BITS-1:0] b;
  logic            ci;
  logic            sub;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] s;
  logic            co;
  logic            ovf;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ovf
  );
endinterface

// File: rtl/cpa_pipe_nbits.sv
// Pipelined carry-propagate adder: one SW-bit segment resolved per stage,
// carry registered between stages, global stall on output backpressure.
module cpa_pipe_nbits #(
  parameter int BITS   = 40,
  parameter int STAGES = 4
) (
  input logic             clk,
  input logic             rst,
  cpa_pipe_nbits_if.slave bus
);
  localparam int SW = BITS / STAGES;

  if (STAGES < 1 || (BITS % STAGES) != 0) begin : g_bad_param
    $error("cpa_pipe_nbits: BITS must be a non-zero multiple of STAGES");
  end

  logic            advance;
  logic            vld_st [STAGES+1];
  logic            cy_st  [STAGES+1];
  logic [BITS-1:0] sum_st [STAGES+1];
  logic [BITS-1:0] a_st   [STAGES];
  logic [BITS-1:0] b_st   [STAGES];
  logic            ovf_w;

  assign advance      = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = advance;

  // Index 0 is the conditioned operand beat feeding stage 0.
  assign vld_st[0] = bus.in_valid;
  assign cy_st[0]  = bus.sub | bus.ci;
  assign sum_st[0] = '0;
  assign a_st[0]   = bus.a;
  assign b_st[0]   = bus.sub ? ~bus.b : bus.b;

  assign bus.out_valid = vld_st[STAGES];
  assign bus.s         = sum_st[STAGES];
  assign bus.co        = cy_st[STAGES];
  assign bus.ovf       = ovf_w;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    logic            vld_q, vld_d;
    logic            cy_q, cy_d;
    logic [BITS-1:0] sum_q, sum_d;
    logic [SW:0]     seg_sum;
    logic            load;

    // Data only moves with a valid beat, so the output holds its last result
    // while bubbles pass through.
    assign load    = advance & vld_st[gi];
    assign seg_sum = {1'b0, a_st[gi][gi*SW +: SW]}
                   + {1'b0, b_st[gi][gi*SW +: SW]}
                   + {{SW{1'b0}}, cy_st[gi]};

    always_comb begin
      vld_d = advance ? vld_st[gi] : vld_q;
      cy_d  = cy_q;
      sum_d = sum_q;
      if (load) begin
        cy_d                = seg_sum[SW];
        sum_d               = sum_st[gi];
        sum_d[gi*SW +: SW]  = seg_sum[SW-1:0];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else begin
        vld_q <= vld_d;
        cy_q  <= cy_d;
        sum_q <= sum_d;
      end
    end

    assign vld_st[gi+1] = vld_q;
    assign cy_st[gi+1]  = cy_q;
    assign sum_st[gi+1] = sum_q;

    if (gi < STAGES-1) begin : g_fwd
      logic [BITS-1:0] a_q, a_d;
      logic [BITS-1:0] b_q, b_d;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (load) begin
          a_d = a_st[gi];
          b_d = b_st[gi];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end

      assign a_st[gi+1] = a_q;
      assign b_st[gi+1] = b_q;
    end else begin : g_last
      logic ovf_q, ovf_d;

      // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
      always_comb begin
        ovf_d = ovf_q;
        if (load) begin
          ovf_d = a_st[gi][BITS-1] ^ b_st[gi][BITS-1] ^ seg_sum[SW-1] ^ seg_sum[SW];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end

      assign ovf_w = ovf_q;
    end
  end
endmodule

// File: tb/tb_cpa_pipe_nbits.sv
// Directed and streaming checks of cpa_pipe_nbits, plus width/depth sweeps
// on BITS=8/STAGES=1 and BITS=64/STAGES=8 instances.
module tb_cpa_pipe_nbits;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  cpa_pipe_nbits_if #(.BITS(40)) bus40 ();
  cpa_pipe_nbits_if #(.BITS(8))  bus8 ();
  cpa_pipe_nbits_if #(.BITS(64)) bus64 ();

  cpa_pipe_nbits #(.BITS(40), .STAGES(4)) dut   (.clk(clk), .rst(rst), .bus(bus40));
  cpa_pipe_nbits #(.BITS(8),  .STAGES(1)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
  cpa_pipe_nbits #(.BITS(64), .STAGES(8)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result packed as {ovf, co, s[63:0]} for a w-bit adder.
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic ci, input logic sub);
    logic [63:0] mask, be, s;
    logic [64:0] t;
    logic        c0, co, ovf;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    be   = (sub ? ~b : b) & mask;
    c0   = sub ? 1'b1 : ci;
    t    = {1'b0, a & mask} + {1'b0, be} + {64'd0, c0};
    s    = t[63:0] & mask;
    co   = t[w];
    ovf  = (a[w-1] == be[w-1]) && (s[w-1] != a[w-1]);
    return {ovf, co, s};
  endfunction

  task automatic beat40(input string tag, input logic [39:0] a, input logic [39:0] b,
                        input logic ci, input logic sub,
                        input logic [39:0] es, input logic eco, input logic eovf);
    bus40.a = a; bus40.b = b; bus40.ci = ci; bus40.sub = sub;
    bus40.in_valid = 1'b1; bus40.out_ready = 1'b1;
    @(posedge clk); #1;
    bus40.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_early"}, {127'd0, bus40.out_valid}, 128'd0);
    @(posedge clk); #1;
    chk({tag, "_result"}, {bus40.out_valid, bus40.s, bus40.co, bus40.ovf}, {1'b1, es, eco, eovf});
    @(posedge clk); #1;
    chk({tag, "_single"}, {127'd0, bus40.out_valid}, 128'd0);
  endtask

  initial begin
    logic [65:0] exp_q[$];
    logic [65:0] e, e64;
    logic [65:0] h8  [16];
    logic [65:0] h64 [16];
    logic [63:0] r;
    logic [39:0] sa, sb;
    logic        sci, ssub, stalled;
    logic [41:0] held;
    int          sent, got;

    bus40.in_valid = 0; bus40.out_ready = 0; bus40.a = '0; bus40.b = '0; bus40.ci = 0; bus40.sub = 0;
    bus8.in_valid  = 0; bus8.out_ready  = 1; bus8.a  = '0; bus8.b  = '0; bus8.ci  = 0; bus8.sub  = 0;
    bus64.in_valid = 0; bus64.out_ready = 1; bus64.a = '0; bus64.b = '0; bus64.ci = 0; bus64.sub = 0;

    #2;
    chk("reset_state", {bus40.out_valid, bus40.s, bus40.co, bus40.ovf, bus40.in_ready},
        {1'b0, 40'd0, 1'b0, 1'b0, 1'b1});
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    beat40("ripple",   40'hFF_FFFF_FFFF, 40'h00_0000_0001, 1'b0, 1'b0, 40'h00_0000_0000, 1'b1, 1'b0);
    beat40("sovf",     40'h7F_FFFF_FFFF, 40'h00_0000_0001, 1'b0, 1'b0, 40'h80_0000_0000, 1'b0, 1'b1);
    beat40("borrow",   40'h00_0000_0005, 40'h00_0000_0007, 1'b1, 1'b1, 40'hFF_FFFF_FFFE, 1'b0, 1'b0);
    beat40("noborrow", 40'h00_0000_0007, 40'h00_0000_0005, 1'b0, 1'b1, 40'h00_0000_0002, 1'b1, 1'b0);
    beat40("carryin",  40'h12_3456_789A, 40'h01_0101_0101, 1'b1, 1'b0, 40'h13_3557_799C, 1'b0, 1'b0);
    beat40("subovf",   40'h80_0000_0000, 40'h00_0000_0001, 1'b0, 1'b1, 40'h7F_FFFF_FFFF, 1'b1, 1'b1);

    // Streaming with random backpressure, scoreboard in acceptance order.
    sent = 0; got = 0; stalled = 1'b0; held = '0;
    r = {$urandom(), $urandom()}; sa = r[39:0];
    r = {$urandom(), $urandom()}; sb = r[39:0];
    sci = 1'($urandom_range(0, 1)); ssub = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      bus40.out_ready = ($urandom_range(0, 9) >= 3);
      bus40.in_valid  = (sent < 20);
      bus40.a = sa; bus40.b = sb; bus40.ci = sci; bus40.sub = ssub;
      #1;
      if (stalled)
        chk("stream_hold", {bus40.out_valid, bus40.s, bus40.co, bus40.ovf}, {1'b1, held});
      chk("stream_in_ready", {127'd0, bus40.in_ready}, {127'd0, !(bus40.out_valid && !bus40.out_ready)});
      if (bus40.out_valid && bus40.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stream_extra", {127'd0, bus40.out_valid}, 128'd0);
        end else begin
          e = exp_q.pop_front();
          chk("stream_result", {bus40.s, bus40.co, bus40.ovf}, {e[39:0], e[64], e[65]});
          got++;
        end
      end
      stalled = bus40.out_valid && !bus40.out_ready;
      held    = {bus40.s, bus40.co, bus40.ovf};
      if (bus40.in_valid && bus40.in_ready) begin
        exp_q.push_back(model(40, {24'd0, sa}, {24'd0, sb}, sci, ssub));
        sent++;
        r = {$urandom(), $urandom()}; sa = r[39:0];
        r = {$urandom(), $urandom()}; sb = r[39:0];
        sci = 1'($urandom_range(0, 1)); ssub = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    bus40.in_valid = 1'b0; bus40.out_ready = 1'b1;
    chk("stream_count", 128'(got), 128'd20);
    chk("stream_leftover", 128'(exp_q.size()), 128'd0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("stream_drain", {127'd0, bus40.out_valid}, 128'd0);
    end

    // Reset with three beats in flight.
    bus40.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r = {$urandom(), $urandom()};
      bus40.a = r[39:0]; bus40.b = r[63:24]; bus40.ci = 1'b0; bus40.sub = 1'b0;
      @(posedge clk); #1;
    end
    bus40.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_async", {bus40.out_valid, bus40.s, bus40.co, bus40.ovf}, 128'd0);
    #9 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      chk("rst_no_emit", {127'd0, bus40.out_valid}, 128'd0);
      @(posedge clk); #1;
    end
    beat40("post_rst", 40'h00_FFFF_FFFF, 40'h00_0000_0001, 1'b0, 1'b0, 40'h01_0000_0000, 1'b0, 1'b0);

    // Sweeps: exhaustive 8-bit operands, 10k random 64-bit beats, exact latency.
    for (int t = 0; t < 65536 + 8; t++) begin
      if (t < 65536) begin
        bus8.in_valid = 1'b1; bus8.a = t[7:0]; bus8.b = t[15:8];
        bus8.sub = 1'($urandom_range(0, 1)); bus8.ci = 1'($urandom_range(0, 1));
        h8[t % 16] = model(8, {56'd0, bus8.a}, {56'd0, bus8.b}, bus8.ci, bus8.sub);
      end else begin
        bus8.in_valid = 1'b0;
      end
      if (t < 10000) begin
        bus64.in_valid = 1'b1;
        bus64.a = {$urandom(), $urandom()}; bus64.b = {$urandom(), $urandom()};
        bus64.sub = 1'($urandom_range(0, 1)); bus64.ci = 1'($urandom_range(0, 1));
        h64[t % 16] = model(64, bus64.a, bus64.b, bus64.ci, bus64.sub);
      end else begin
        bus64.in_valid = 1'b0;
      end
      #1;
      e = h8[(t + 15) % 16];
      if (t >= 1 && t <= 65536)
        chk("sweep8", {bus8.out_valid, bus8.s, bus8.co, bus8.ovf}, {1'b1, e[7:0], e[64], e[65]});
      else
        chk("sweep8_idle", {127'd0, bus8.out_valid}, 128'd0);
      e64 = h64[(t + 8) % 16];
      if (t >= 8 && t < 10008)
        chk("sweep64", {bus64.out_valid, bus64.s, bus64.co, bus64.ovf}, {1'b1, e64[63:0], e64[64], e64[65]});
      else if (t < 10016)
        chk("sweep64_idle", {127'd0, bus64.out_valid}, 128'd0);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cpa_pipe_nbits.md
Name: cpa_pipe_nbits

Overview:
- Parametrised, pipelined successor to the combinational 40-bit final carry-propagate adder. It resolves the multiplier tree's partial vectors into pv_prime.
- The BITS-wide operand pair is split into STAGES equal segments. One segment is added per pipeline stage, with the carry registered between stages.
- Adds a valid/ready handshake with backpressure, per-transaction subtract mode, carry-in, carry-out and signed-overflow.

Parameters:
- BITS, 40, operand/result width.
- STAGES, 4, pipeline depth and segment count. BITS % STAGES must be 0, otherwise elaboration error. STAGES=1 is a single registered adder.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  BITS  operand A.
- b  input  BITS  operand B.
- ci  input  1  carry-in (add mode only).
- sub  input  1  1: compute a - b; 0: compute a + b + ci.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- s  output  BITS  result.
- co  output  1  carry-out; in sub mode, 1 = no borrow (a >= b unsigned).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (async assert, sync deassert to clk):
  - All stage valid bits, out_valid, s, co and ovf are 0.
  - in_ready is 1 while out_valid=0.
  - Reset mid-operation discards all in-flight beats; nothing partial is emitted.
- Segment width: SW = BITS/STAGES. Segment k covers bits [k*SW+SW-1 : k*SW].
- Operand conditioning at capture:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : ci (ci ignored when sub=1).
- Pipeline stage k (k=0..STAGES-1):
  - Computes segment k of a + b_eff + carry_k. carry_0 = c0; carry_k is stage k-1's registered carry-out.
  - Carries forward registered copies of segments k+1..STAGES-1 of a and b_eff (operand skew).
  - Carries forward the already-resolved low segments 0..k-1 (result deskew).
  - Sign bits a[BITS-1] and b_eff[BITS-1] travel with the beat for the ovf computation.
- Final stage outputs:
  - s = full BITS-wide sum.
  - co = carry out of bit BITS-1.
  - ovf = carry into bit BITS-1 XOR co.
- Latency: a beat accepted on cycle N (in_valid & in_ready) appears with out_valid=1 on cycle N+STAGES, provided no stall occurs. Throughput is 1 beat/cycle.
- Flow control (global stall, no bubbles squeezed):
  - advance = out_ready | ~out_valid.
  - in_ready = advance (combinational from out_ready and out_valid only, not from in_valid).
  - When advance=0, every stage register holds, including valid bits. s/co/ovf remain stable while out_valid=1 and out_ready=0.
  - When advance=1, each stage loads from its predecessor. Stage 0 loads valid = in_valid.
  - Bubbles (invalid beats) propagate as valid=0. Data registers of invalid stages may hold anything. s/co/ovf keep their last value while out_valid=0.
- Simultaneous events: out_ready=1 with out_valid=1 and in_valid=1 retires one beat and accepts one beat in the same cycle.
- Wrap-around: s is modulo 2^BITS. Overflow is reported only via co/ovf and is never saturated.
- Sub mode result: s = a - b mod 2^BITS, i.e. a + ~b + 1.
- Behaviour per beat is independent of its neighbours; there is no accumulation across beats.

Test Plan:
- BITS=40, STAGES=4:
  - Stimulus: a=0xFF_FFFF_FFFF, b=0x00_0000_0001, ci=0, sub=0, out_ready=1.
  - Required: exactly 4 cycles later s=0, co=1, ovf=0. The carry ripples through all four segments.
- Signed overflow:
  - Stimulus: a=0x7F_FFFF_FFFF, b=1, sub=0.
  - Required: s=0x80_0000_0000, co=0, ovf=1.
- Subtract with borrow:
  - Stimulus: sub=1, a=5, b=7, ci=1 (must be ignored).
  - Required: s=0xFF_FFFF_FFFE, co=0, ovf=0.
- Sub mode without borrow:
  - Stimulus: sub=1, a=7, b=5.
  - Required: s=2, co=1.
- Streaming with backpressure:
  - Stimulus: 20 back-to-back random beats. out_ready is pseudo-randomly deasserted about 30% of the time.
  - Required:
    - All 20 results in order and matching a reference model.
    - in_ready=0 exactly when out_valid=1 and out_ready=0.
    - s stable during stalls.
    - No beat lost or duplicated.
- Reset mid-flight:
  - Stimulus: 3 beats accepted, then rst pulsed asynchronously (between clock edges) for 1 cycle.
  - Required:
    - out_valid=0 and s=0 immediately.
    - None of the 3 beats is ever emitted.
    - The next beat after reset emerges with latency 4.
- Parameter sweep (BITS=8, STAGES=1; BITS=64, STAGES=8):
  - Stimulus: exhaustive (8-bit) or 10k random vectors with random sub/ci.
  - Required: latency equals STAGES, and s/co/ovf match the model.
